// File: rtl/nms_pkg.sv
// Shared types and helpers for the streaming non-maximum suppression block.
package nms_pkg;

  localparam int SCORE_BITS = 8;

  // Default-width signed corner score.
  typedef logic signed [SCORE_BITS-1:0] score_t;

  // Counter width for a coordinate that ranges over 0..n-1.
  function automatic int coord_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // True when window cell (row,col) comes before the centre (crow,ccol) in raster order.
  function automatic logic precedes(input int row, input int col, input int crow, input int ccol);
    return (row < crow) || ((row == crow) && (col < ccol));
  endfunction

endpackage

// File: rtl/nms_line_buffer.sv
// One image line of scores. The read is combinational and the write is
// registered, so a same-cycle read at the write address returns the old value.
module nms_line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  // Store the incoming score for this column; contents are never reset.
  always_ff @(posedge clk) begin
    if (en) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/nms_stream.sv
// Streaming non-maximum suppression over a WINDOW_WIDTH x WINDOW_HEIGHT window.
// Optional build macro NMS_SCORE_OUT_EN adds out_score (registered centre score).
module nms_stream
  import nms_pkg::*;
#(
  parameter int DATA_BITS     = SCORE_BITS,
  parameter int WINDOW_WIDTH  = 3,
  parameter int WINDOW_HEIGHT = 3,
  parameter int IMAGE_WIDTH   = 640,
  parameter int IMAGE_HEIGHT  = 480,
  parameter int THRESHOLD     = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_sof,
  input  logic [DATA_BITS-1:0]            in_score,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_is_max,
  output logic [$clog2(IMAGE_WIDTH)-1:0]  out_x,
  output logic [$clog2(IMAGE_HEIGHT)-1:0] out_y
`ifdef NMS_SCORE_OUT_EN
  ,
  output logic [DATA_BITS-1:0]            out_score
`endif
);

  localparam int RX  = (WINDOW_WIDTH - 1) / 2;
  localparam int RY  = (WINDOW_HEIGHT - 1) / 2;
  localparam int XW  = coord_bits(IMAGE_WIDTH);
  localparam int YW  = coord_bits(IMAGE_HEIGHT);
  localparam int NLB = WINDOW_HEIGHT - 1;

  localparam logic [XW-1:0] X_LAST = XW'(IMAGE_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_HEIGHT - 1);
  localparam logic [XW-1:0] X_MIN  = XW'(2 * RX);
  localparam logic [YW-1:0] Y_MIN  = YW'(2 * RY);
  localparam logic [XW-1:0] X_OFF  = XW'(RX);
  localparam logic [YW-1:0] Y_OFF  = YW'(RY);

  logic                        en;
  logic                        accept;
  logic [XW-1:0]               x, cur_x, tag_x;
  logic [YW-1:0]               y, cur_y, tag_y;
  logic                        tag_emit;
  logic                        is_max_c;
  logic signed [DATA_BITS-1:0] ctr;
  logic [DATA_BITS-1:0]        lb_rd   [NLB];
  logic [DATA_BITS-1:0]        new_col [WINDOW_HEIGHT];
  logic [DATA_BITS-1:0]        win     [WINDOW_HEIGHT][WINDOW_WIDTH];

  // The whole pipeline advances together; a stalled output freezes everything.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  // A start-of-frame beat is position (0,0) regardless of the running counters.
  assign cur_x = in_sof ? '0 : x;
  assign cur_y = in_sof ? '0 : y;

  // Line buffers are chained: each one is fed by the row below it.
  for (genvar k = 0; k < NLB; k++) begin : g_lb
    logic [DATA_BITS-1:0] wr_data;
    if (k == 0) begin : g_head
      assign wr_data = in_score;
    end else begin : g_tail
      assign wr_data = lb_rd[k-1];
    end
    nms_line_buffer #(
      .DEPTH(IMAGE_WIDTH),
      .WIDTH(DATA_BITS),
      .AW   (XW)
    ) u_lb (
      .clk    (clk),
      .en     (accept),
      .addr   (cur_x),
      .wr_data(wr_data),
      .rd_data(lb_rd[k])
    );
  end

  // Newest window column: oldest line on top, live score at the bottom.
  for (genvar r = 0; r < WINDOW_HEIGHT; r++) begin : g_col
    if (r == WINDOW_HEIGHT - 1) begin : g_live
      assign new_col[r] = in_score;
    end else begin : g_buf
      assign new_col[r] = lb_rd[WINDOW_HEIGHT-2-r];
    end
  end

  // Shift the window one column left and load the new column on each accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < WINDOW_HEIGHT; r++) begin
        for (int c = 0; c < WINDOW_WIDTH - 1; c++) win[r][c] <= win[r][c+1];
        win[r][WINDOW_WIDTH-1] <= new_col[r];
      end
    end
  end

  // Raster counters and the stage-1 tag describing the window centre.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x        <= '0;
      y        <= '0;
      tag_emit <= 1'b0;
      tag_x    <= '0;
      tag_y    <= '0;
    end else if (accept) begin
      tag_emit <= (cur_x >= X_MIN) && (cur_y >= Y_MIN);
      tag_x    <= cur_x - X_OFF;
      tag_y    <= cur_y - Y_OFF;
      if (cur_x == X_LAST) begin
        x <= '0;
        y <= (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
      end else begin
        x <= cur_x + 1'b1;
        y <= cur_y;
      end
    end else if (en) begin
      tag_emit <= 1'b0;
    end
  end

  assign ctr = win[RY][RX];

  // Centre wins if above threshold, strictly beats earlier cells and ties-or-beats later ones.
  always_comb begin
    is_max_c = (int'(ctr) >= THRESHOLD);
    for (int r = 0; r < WINDOW_HEIGHT; r++) begin
      for (int c = 0; c < WINDOW_WIDTH; c++) begin
        if (precedes(r, c, RY, RX)) begin
          is_max_c = is_max_c && ($signed(win[r][c]) < ctr);
        end else if (!((r == RY) && (c == RX))) begin
          is_max_c = is_max_c && ($signed(win[r][c]) <= ctr);
        end
      end
    end
  end

  // Output register stage; holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_is_max <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
`ifdef NMS_SCORE_OUT_EN
      out_score  <= '0;
`endif
    end else if (en) begin
      out_valid  <= tag_emit;
      out_is_max <= is_max_c;
      out_x      <= tag_x;
      out_y      <= tag_y;
`ifdef NMS_SCORE_OUT_EN
      out_score  <= ctr;
`endif
    end
  end

endmodule
